// File: rtl/dm_cache_pkg.sv
// Shared defaults, FSM state encoding and address-field helpers for the direct-mapped cache.
package dm_cache_pkg;

   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_INDEX_W  = 5;
   localparam int DEF_OFFSET_W = 2;
   localparam int DEF_STAT_W   = 16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REFILL = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;

   // Word address layout is {tag, index, offset}; callers size-cast the result.
   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w,
                                            input int offset_w);
      return addr >> (index_w + offset_w);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w,
                                              input int offset_w);
      return (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int offset_w);
      return addr & ((32'd1 << offset_w) - 32'd1);
   endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache with combinational tag compare.
module dm_cache_array
   import dm_cache_pkg::*;
#(
   parameter int INDEX_W  = DEF_INDEX_W,
   parameter int OFFSET_W = DEF_OFFSET_W,
   parameter int TAG_W    = 3,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [INDEX_W-1:0]  idx,
   input  logic [OFFSET_W-1:0] off,
   input  logic [TAG_W-1:0]    tag,
   output logic                hit,
   output logic [DATA_W-1:0]   rdata,
   input  logic                word_we,
   input  logic [DATA_W-1:0]   word_data,
   input  logic                fill_we,
   input  logic [OFFSET_W-1:0] fill_off,
   input  logic [DATA_W-1:0]   fill_data,
   input  logic                line_set
);

   localparam int LINES = 2**INDEX_W;
   localparam int WORDS = 2**OFFSET_W;

   logic [LINES-1:0]             valid;
   logic [TAG_W-1:0]             tag_mem  [LINES];
   logic [WORDS-1:0][DATA_W-1:0] data_mem [LINES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        valid      <= '0;
      else if (line_set) valid[idx] <= 1'b1;
   end

   // Tag and data carry no reset; an invalid line is never trusted.
   always_ff @(posedge clk) begin
      if (line_set) tag_mem[idx] <= tag;
      if (fill_we)      data_mem[idx][fill_off] <= fill_data;
      else if (word_we) data_mem[idx][off]      <= word_data;
   end

   assign hit   = valid[idx] && (tag_mem[idx] == tag);
   assign rdata = data_mem[idx][off];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through, read-allocate cache with line refill FSM and
// saturating hit/miss statistics.
module dm_cache_ctrl
   import dm_cache_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int INDEX_W  = DEF_INDEX_W,
   parameter int OFFSET_W = DEF_OFFSET_W,
   parameter int STAT_W   = DEF_STAT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [STAT_W-1:0] hit_cnt,
   output logic [STAT_W-1:0] miss_cnt
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

   if (TAG_W < 1) begin : g_tag_w_chk
      $error("dm_cache_ctrl: ADDR_W leaves no tag bits after INDEX_W + OFFSET_W");
   end

   logic [1:0]          state;
   logic [OFFSET_W-1:0] beat;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;

   logic [TAG_W-1:0]    tag;
   logic [INDEX_W-1:0]  idx;
   logic [OFFSET_W-1:0] off;
   logic                hit, req, fill_we, line_set, word_we, cnt_hit, cnt_miss;

   assign tag = TAG_W'(addr_tag(32'(cpu_addr), INDEX_W, OFFSET_W));
   assign idx = INDEX_W'(addr_index(32'(cpu_addr), INDEX_W, OFFSET_W));
   assign off = OFFSET_W'(addr_offset(32'(cpu_addr), OFFSET_W));

   assign req      = cpu_rd || cpu_wr;
   assign fill_we  = (state == ST_REFILL) && mem_ready;
   assign line_set = fill_we && (beat == '1);
   assign word_we  = (state == ST_IDLE) && cpu_wr && hit;
   assign cnt_hit  = (state == ST_IDLE) && req && hit;
   assign cnt_miss = (state == ST_IDLE) && req && !hit;

   dm_cache_array #(
      .INDEX_W  (INDEX_W),
      .OFFSET_W (OFFSET_W),
      .TAG_W    (TAG_W),
      .DATA_W   (DATA_W)
   ) u_array (
      .clk       (clk),
      .reset     (reset),
      .idx       (idx),
      .off       (off),
      .tag       (tag),
      .hit       (hit),
      .rdata     (cpu_rdata),
      .word_we   (word_we),
      .word_data (cpu_wdata),
      .fill_we   (fill_we),
      .fill_off  (beat),
      .fill_data (mem_rdata),
      .line_set  (line_set)
   );

   // The core holds its request through a refill, so the refill address
   // comes straight from cpu_addr rather than a latched copy.
   always_comb begin
      cpu_stall = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         ST_IDLE:   cpu_stall = cpu_wr || (cpu_rd && !hit);
         ST_REFILL: begin
            cpu_stall = 1'b1;
            mem_rd    = 1'b1;
            mem_addr  = {tag, idx, beat};
         end
         ST_WRITE:  begin
            cpu_stall = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = wr_addr_q;
            mem_wdata = wr_data_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         beat      <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_wr) begin
                  wr_addr_q <= cpu_addr;
                  wr_data_q <= cpu_wdata;
                  state     <= ST_WRITE;
               end else if (cpu_rd && !hit) begin
                  beat  <= '0;
                  state <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               // beat wraps to zero on the last word, ready for the next refill
               if (mem_ready) begin
                  beat <= beat + 1'b1;
                  if (beat == '1) state <= ST_IDLE;
               end
            end
            ST_WRITE: if (mem_ready) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (cnt_hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + 1'b1;
         if (cnt_miss && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
   end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Parametrised direct-mapped, write-through, read-allocate cache with stored tags and an integrated miss-handling FSM.
- Sits between the RISC-V core's data port and the word-wide main-memory model.
- Replaces the separate cache array and external hit/miss controller: it computes hit/miss itself and performs the multi-beat line refill with a beat counter.
- Adds saturating hit/miss statistics counters.

Parameters:
- ADDR_W, 10, word-address width from the core.
- DATA_W, 32, word width.
- INDEX_W, 5, line-index bits; lines = 2**INDEX_W.
- OFFSET_W, 2, word-in-line bits; words per line = 2**OFFSET_W.
- STAT_W, 16, statistics counter width.
- Derived: TAG_W = ADDR_W-INDEX_W-OFFSET_W. Elaboration error if TAG_W < 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  read request.
- cpu_wr  in  1  write request.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid when cpu_rd & !cpu_stall.
- cpu_stall  out  1  core must hold its request stable while high.
- mem_rd  out  1  memory read request (one word).
- mem_wr  out  1  memory write request (one word).
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse per word.
- hit_cnt  out  STAT_W  saturating hit count.
- miss_cnt  out  STAT_W  saturating miss count.

Behaviour:
- Storage per line: valid bit, TAG_W tag, 2**OFFSET_W data words. hit = valid[idx] & (tag[idx] == addr tag field).
- Reset: FSM -> IDLE; all valid bits cleared; beat = 0; hit_cnt = miss_cnt = 0. All outputs 0 except cpu_rdata. Data/tag arrays are not reset.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, cpu_rd hit:
  - cpu_rdata combinational from the addressed word; cpu_stall = 0; zero-wait.
  - hit_cnt++ on that clock edge.
- IDLE, cpu_rd miss:
  - cpu_stall = 1 combinationally in the same cycle.
  - miss_cnt++; go to REFILL with beat = 0.
- REFILL:
  - mem_rd = 1; mem_addr = {tag, idx, beat}.
  - Each mem_ready: write mem_rdata into word[beat], then beat++.
  - On the last beat (beat == all ones): set valid and tag, clear beat, go to IDLE.
  - cpu_stall stays 1 throughout REFILL.
  - The held request then hits in IDLE on the next cycle and increments hit_cnt. A read miss therefore counts one miss and one hit.
- IDLE, cpu_wr (write-through, no-write-allocate):
  - If hit, update the addressed word on that edge; count a hit. Otherwise count a miss; the line is untouched.
  - Latch address/data, go to WRITE; cpu_stall = 1 from the request cycle.
- WRITE:
  - mem_wr = 1 with the latched mem_addr/mem_wdata until mem_ready; then go to IDLE.
  - cpu_stall falls in the IDLE cycle after mem_ready. The core must deassert cpu_wr at that edge, or the write repeats.
- cpu_rd and cpu_wr both high: the write wins; the read is ignored.
- mem_rd and mem_wr are never both high. mem_ready outside REFILL/WRITE is ignored.
- Counters saturate at all ones; no wrap.
- Reset mid-REFILL or mid-WRITE: immediate return to IDLE, partial line discarded (valid stays 0), pending write dropped.
- cpu_rdata when not a read hit: holds the last driven value (registered-free mux output of the current index is acceptable). The bench must not check it.

Decomposition:
- Shared package dm_cache_pkg:
  - FSM state encoding (IDLE=2'd0, REFILL=2'd1, WRITE=2'd2).
  - Default parameter constants.
  - Functions to extract the tag/index/offset fields.
- One sub-module, dm_cache_array: valid/tag/data storage with async valid clear, a word-write port and a line-fill word port, plus combinational tag compare producing hit.
- FSM, beat counter and statistics live in dm_cache_ctrl.

Test Plan:
1. Cold read: reset, cpu_rd addr 0x084 → miss_cnt = 1. Exactly 4 mem_rd beats at addresses 0x084..0x087. Stall for 4 mem_ready cycles. Then cpu_rdata = word from 0x084; hit_cnt = 1.
2. Read hit: after test 1, read 0x086 → no stall, cpu_rdata = memory[0x086], hit_cnt = 2.
3. Conflict eviction: read 0x104 (same index, tag 2) → refill, then read 0x084 → miss again; miss_cnt increments each time.
4. Write hit: write 0xDEADBEEF to cached 0x085 → one mem_wr at 0x085, stall until mem_ready. Subsequent read of 0x085 hits with 0xDEADBEEF.
5. Write miss: write to uncached 0x300 → mem_wr issued. A following read of 0x300 misses and refills; no allocate on write.
6. Reset after 2 refill beats: line stays invalid, FSM idle, counters 0. Re-read of the same address performs a full 4-beat refill.
